// File: rtl/vram_fetch_if.sv
// VRAM read port and output word stream for vram_fetch.
// master = fetch block side, slave = VRAM + pixel pipeline side.
interface vram_fetch_if #(
    parameter int ADDR_W = 15
);
    logic              vram_en;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_dout;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;

    modport master (
        output vram_en, vram_we, vram_addr, out_valid, out_data,
        input  vram_dout, out_ready
    );

    modport slave (
        input  vram_en, vram_we, vram_addr, out_valid, out_data,
        output vram_dout, out_ready
    );
endinterface

// File: rtl/vram_fetch.sv
// vram_fetch: per-line character/attribute fetcher for the display port of
// the video RAM. Reads {char, attr} byte pairs, packs them into 16-bit words
// and buffers them in a small FIFO ahead of the character generator.
// Optional macro VRAM_FETCH_UNDERRUN_EN adds the underrun_cnt output, which
// counts cycles the consumer is starved while a line is being fetched.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no line in progress, waiting for line_start
// RD_CHAR | issue the char read once a FIFO slot can be reserved
// RD_ATTR | issue the attr read, capture the char byte
// LAST    | final attr byte returns, push the last pair, pulse line_done
module vram_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [7:0]        line_len,
    output logic              busy,
    output logic              line_done,
`ifdef VRAM_FETCH_UNDERRUN_EN
    output logic [15:0]       underrun_cnt,
`endif
    vram_fetch_if.master      bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RD_CHAR, RD_ATTR, LAST} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remaining;
    logic [7:0]        char_q;
    logic              attr_pending;
    logic [1:0]        in_flight;
    logic              zero_done;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [CNT_W:0]    credit_sum;
    logic              credit_ok;
    logic              char_issue, attr_issue, push, pop;

    // A FIFO slot is reserved when the char read issues, so count in-flight pairs.
    assign credit_sum = {1'b0, fifo_count} + (CNT_W+1)'(in_flight);
    assign credit_ok  = credit_sum < (CNT_W+1)'(FIFO_DEPTH);
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && bus.out_ready && !line_start;

    assign bus.vram_en   = char_issue | attr_issue;
    assign bus.vram_we   = 1'b0;
    assign bus.vram_addr = addr;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = mem[rd_ptr];
    assign busy          = (state != IDLE) || !fifo_empty;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; line_start overrides whatever line is in progress.
    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = (line_len == 8'd0) ? IDLE : RD_CHAR;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RD_CHAR: if (credit_ok) state_nxt = RD_ATTR;
                RD_ATTR: state_nxt = (remaining > 8'd1) ? RD_CHAR : LAST;
                LAST:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Read strobes, FIFO push and line_done; all suppressed by an abort.
    always_comb begin
        char_issue = 1'b0;
        attr_issue = 1'b0;
        push       = 1'b0;
        line_done  = zero_done;
        if (!line_start) begin
            char_issue = (state == RD_CHAR) && credit_ok;
            attr_issue = (state == RD_ATTR);
            push       = attr_pending;
            line_done  = zero_done | (state == LAST);
        end
    end

    // Line address/length tracking and pair assembly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= '0;
            remaining    <= '0;
            char_q       <= '0;
            attr_pending <= 1'b0;
            in_flight    <= '0;
            zero_done    <= 1'b0;
        end else if (line_start) begin
            addr         <= line_addr;
            remaining    <= line_len;
            attr_pending <= 1'b0;
            in_flight    <= '0;
            zero_done    <= (line_len == 8'd0);
        end else begin
            zero_done    <= 1'b0;
            attr_pending <= attr_issue;
            if (char_issue || attr_issue) addr <= addr + ADDR_W'(1);
            if (attr_issue) begin
                remaining <= remaining - 8'd1;
                char_q    <= bus.vram_dout;
            end
            case ({char_issue, push})
                2'b10:   in_flight <= in_flight + 2'd1;
                2'b01:   in_flight <= in_flight - 2'd1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Word FIFO; a line_start flush beats any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (line_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.vram_dout, char_q};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef VRAM_FETCH_UNDERRUN_EN
    // Count cycles the consumer waits on an empty FIFO during a line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= '0;
        end else if (line_start) begin
            underrun_cnt <= '0;
        end else if (bus.out_ready && fifo_empty && (state != IDLE) &&
                     (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_fetch.sv
// Directed bench for vram_fetch with a registered-read VRAM model.
module tb_vram_fetch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [14:0] line_addr = '0;
    logic [7:0]  line_len = '0;
    logic        busy, line_done;
`ifdef VRAM_FETCH_UNDERRUN_EN
    logic [15:0] underrun_cnt;
`endif

    vram_fetch_if #(.ADDR_W(15)) bus ();

    vram_fetch #(.FIFO_DEPTH(4), .ADDR_W(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .line_start   (line_start),
        .line_addr    (line_addr),
        .line_len     (line_len),
        .busy         (busy),
        .line_done    (line_done),
`ifdef VRAM_FETCH_UNDERRUN_EN
        .underrun_cnt (underrun_cnt),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // VRAM model: registered read, data valid the cycle after vram_en.
    logic [7:0] vram [0:32767];
    logic [7:0] vram_q = 8'h00;
    always @(posedge clk) if (bus.vram_en) vram_q <= vram[bus.vram_addr];
    assign bus.vram_dout = vram_q;

    int          checks = 0;
    int          failures = 0;
    logic [14:0] rd_log [$];
    logic [15:0] words [$];
    int          done_cnt = 0;
    int          valid_cycles = 0;

    // Monitor on the falling edge: reads issued, words accepted, done pulses.
    always @(negedge clk) begin
        if (bus.vram_en) rd_log.push_back(bus.vram_addr);
        if (bus.out_valid && bus.out_ready && !line_start) words.push_back(bus.out_data);
        if (line_done) done_cnt++;
        if (bus.out_valid) valid_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        words.delete();
        done_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic start_line(input logic [14:0] a, input logic [7:0] l);
        line_addr  = a;
        line_len   = l;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, busy, limit);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        checks += 7;
        if (bus.vram_en !== 1'b0) begin failures++; $display("FAIL reset_vram_en: got %b, required 0", bus.vram_en); end
        if (bus.vram_we !== 1'b0) begin failures++; $display("FAIL reset_vram_we: got %b, required 0", bus.vram_we); end
        if (bus.vram_addr !== 15'h0) begin failures++; $display("FAIL reset_vram_addr: got %h, required 0", bus.vram_addr); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data: got %h, required 0", bus.out_data); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (line_done !== 1'b0) begin failures++; $display("FAIL reset_line_done: got %b, required 0", line_done); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0741; exp_w[1] = 16'h1F42; exp_w[2] = 16'h7043;
        vram[0] = 8'h41; vram[1] = 8'h07; vram[2] = 8'h42;
        vram[3] = 8'h1F; vram[4] = 8'h43; vram[5] = 8'h70;
        clear_logs();
        bus.out_ready = 1'b1;
        start_line(15'h0000, 8'd3);
        wait_idle(60, "basic_idle");
        tick();
        checks++;
        if (words.size() != 3) begin failures++; $display("FAIL basic_count: got %0d words, required 3", words.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= words.size() || words[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL basic_word%0d: got %h, required %h", i, (i < words.size()) ? words[i] : 16'hxxxx, exp_w[i]);
            end
        end
        checks += 2;
        if (done_cnt != 1) begin failures++; $display("FAIL basic_line_done: got %0d pulses, required 1", done_cnt); end
        if (rd_log.size() != 6) begin failures++; $display("FAIL basic_reads: got %0d reads, required 6", rd_log.size()); end
    endtask

    task automatic test_wrap();
        logic [14:0] exp_a [4];
        exp_a[0] = 15'h7FFE; exp_a[1] = 15'h7FFF; exp_a[2] = 15'h0000; exp_a[3] = 15'h0001;
        vram[15'h7FFE] = 8'h58; vram[15'h7FFF] = 8'h0F; vram[0] = 8'h59; vram[1] = 8'h0E;
        clear_logs();
        bus.out_ready = 1'b1;
        start_line(15'h7FFE, 8'd2);
        wait_idle(60, "wrap_idle");
        checks += 3;
        if (words.size() != 2) begin failures++; $display("FAIL wrap_count: got %0d words, required 2", words.size()); end
        if (words.size() < 1 || words[0] !== 16'h0F58) begin failures++; $display("FAIL wrap_word0: required 0f58"); end
        if (words.size() < 2 || words[1] !== 16'h0E59) begin failures++; $display("FAIL wrap_word1: required 0e59"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= rd_log.size() || rd_log[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL wrap_addr%0d: got %h, required %h", i, (i < rd_log.size()) ? rd_log[i] : 15'hxxxx, exp_a[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp;
        int bad = 0;
        for (int i = 0; i < 160; i++) vram[15'h0100 + i] = 8'(i * 7 + 3);
        clear_logs();
        bus.out_ready = 1'b0;
        start_line(15'h0100, 8'd80);
        repeat (40) tick();
        checks += 4;
        if (rd_log.size() != 8) begin failures++; $display("FAIL stall_reads: got %0d reads, required 8", rd_log.size()); end
        if (words.size() != 0) begin failures++; $display("FAIL stall_words: got %0d words, required 0", words.size()); end
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b, required 1", bus.out_valid); end
        if (bus.vram_en !== 1'b0) begin failures++; $display("FAIL stall_vram_en: got %b, required 0", bus.vram_en); end
        bus.out_ready = 1'b1;
        wait_idle(600, "stall_idle");
        checks += 3;
        if (words.size() != 80) begin failures++; $display("FAIL stall_count: got %0d words, required 80", words.size()); end
        if (rd_log.size() != 160) begin failures++; $display("FAIL stall_total_reads: got %0d, required 160", rd_log.size()); end
        if (done_cnt != 1) begin failures++; $display("FAIL stall_line_done: got %0d pulses, required 1", done_cnt); end
        for (int i = 0; i < 80; i++) begin
            exp = {vram[15'h0101 + 2*i], vram[15'h0100 + 2*i]};
            checks++;
            if (i >= words.size() || words[i] !== exp) begin
                failures++;
                if (bad < 5) $display("FAIL stall_word%0d: got %h, required %h", i, (i < words.size()) ? words[i] : 16'hxxxx, exp);
                bad++;
            end
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int w0, r0;
        for (int i = 0; i < 80; i++) vram[15'h0200 + i] = 8'(i) ^ 8'hA5;
        vram[15'h1000] = 8'h61; vram[15'h1001] = 8'h1E; vram[15'h1002] = 8'h62; vram[15'h1003] = 8'h2F;
        clear_logs();
        bus.out_ready = 1'b1;
        start_line(15'h0200, 8'd40);
        while (words.size() < 5 && n < 100) begin tick(); n++; end
        checks++;
        if (words.size() < 5) begin failures++; $display("FAIL abort_wait: got %0d words, required 5", words.size()); end
        w0 = words.size();
        r0 = rd_log.size();
        start_line(15'h1000, 8'd2);
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_flush: out_valid got %b, required 0", bus.out_valid); end
        wait_idle(60, "abort_idle");
        checks += 6;
        if (words.size() != w0 + 2) begin failures++; $display("FAIL abort_count: got %0d words, required %0d", words.size(), w0 + 2); end
        if (words.size() < w0 + 1 || words[w0] !== 16'h1E61) begin failures++; $display("FAIL abort_word0: required 1e61"); end
        if (words.size() < w0 + 2 || words[w0+1] !== 16'h2F62) begin failures++; $display("FAIL abort_word1: required 2f62"); end
        if (rd_log.size() < r0 + 1 || rd_log[r0] !== 15'h1000) begin failures++; $display("FAIL abort_addr0: required 1000"); end
        if (rd_log.size() < r0 + 2 || rd_log[r0+1] !== 15'h1001) begin failures++; $display("FAIL abort_addr1: required 1001"); end
        if (done_cnt != 1) begin failures++; $display("FAIL abort_line_done: got %0d pulses, required 1", done_cnt); end
    endtask

    task automatic test_empty();
        clear_logs();
        bus.out_ready = 1'b1;
        start_line(15'h0040, 8'd0);
        repeat (10) tick();
        checks += 4;
        if (rd_log.size() != 0) begin failures++; $display("FAIL empty_reads: got %0d, required 0", rd_log.size()); end
        if (done_cnt != 1) begin failures++; $display("FAIL empty_line_done: got %0d pulses, required 1", done_cnt); end
        if (valid_cycles != 0) begin failures++; $display("FAIL empty_valid: got %0d valid cycles, required 0", valid_cycles); end
        if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy: got %b, required 0", busy); end
    endtask

`ifdef VRAM_FETCH_UNDERRUN_EN
    task automatic test_underrun();
        clear_logs();
        bus.out_ready = 1'b1;
        start_line(15'h0000, 8'd4);
        wait_idle(60, "underrun_idle");
        checks++;
        if (underrun_cnt === 16'h0) begin failures++; $display("FAIL underrun_count: got %h, required nonzero", underrun_cnt); end
        start_line(15'h0000, 8'd0);
        checks++;
        if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL underrun_clear: got %h, required 0", underrun_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) vram[i] = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_abort();
        test_empty();
`ifdef VRAM_FETCH_UNDERRUN_EN
        test_underrun();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
